rob_multi: RTL and testbench

Parametrised reorder buffer (ROB) for the out-of-order core. Generalises the single-CDB, single-commit ROB entry scheme to:
- N_CDB simultaneous result broadcasts per cycle
- N_READ operand lookup ports, each with CDB bypass
- up to COMMIT_WIDTH in-order retirements per cycle
- synchronous flush on branch mispredict

It sits between issue/rename (allocation, operand lookup), the execution units (CDB) and the commit ring (retirement).

---
 rtl/rob_multi.sv | 148 ++++++++++++++
 tb/tb_rob_multi.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_multi.sv
// Reorder buffer: allocation at tail, N_CDB result broadcasts, N_READ bypassed
// operand lookups and up to COMMIT_WIDTH in-order retirements from head.
module rob_multi #(
  parameter int ROB_WIDTH    = 4,
  parameter int REG_WIDTH    = 5,
  parameter int N_CDB        = 3,
  parameter int N_READ       = 2,
  parameter int COMMIT_WIDTH = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              alloc_req,
  input  logic [REG_WIDTH-1:0]              alloc_arch,
  output logic                              alloc_ready,
  output logic [ROB_WIDTH-1:0]              alloc_tag,
  input  logic [N_CDB-1:0]                  cdb_valid,
  input  logic [N_CDB*ROB_WIDTH-1:0]        cdb_tag,
  input  logic [N_CDB*32-1:0]               cdb_data,
  input  logic [N_READ*ROB_WIDTH-1:0]       read_tag,
  output logic [N_READ-1:0]                 read_valid,
  output logic [N_READ*32-1:0]              read_data,
  output logic [COMMIT_WIDTH-1:0]           commit_valid,
  output logic [COMMIT_WIDTH*REG_WIDTH-1:0] commit_arch,
  output logic [COMMIT_WIDTH*32-1:0]        commit_data,
  input  logic [COMMIT_WIDTH-1:0]           commit_ack,
  input  logic                              flush,
  output logic [ROB_WIDTH:0]                count
);
  localparam int DEPTH = 2 ** ROB_WIDTH;
  localparam int PW    = ROB_WIDTH + 1;

  // Handshakes: an entry is allocated on any rising edge with alloc_req && alloc_ready
  // (alloc_ready depends only on registered state); commit lane k retires when
  // commit_valid[k] && commit_ack[k] and every lower lane retires too.

  logic [PW-1:0]        head, tail, occ, n_retire;
  logic [ROB_WIDTH-1:0] head_idx, tail_idx;
  logic [DEPTH-1:0]     ent_valid;
  logic [REG_WIDTH-1:0] ent_arch [DEPTH];
  logic [31:0]          ent_data [DEPTH];
  logic                 fire;
  logic [DEPTH-1:0]     cdb_we, ret_clr, alloc_clr;
  logic [31:0]          cdb_wd [DEPTH];
  logic [N_CDB-1:0]     cdb_hit;
  logic [ROB_WIDTH-1:0] lane_idx [COMMIT_WIDTH];
  logic [COMMIT_WIDTH-1:0] lane_ok;

  assign head_idx    = head[ROB_WIDTH-1:0];
  assign tail_idx    = tail[ROB_WIDTH-1:0];
  assign occ         = tail - head;
  assign count       = occ;
  assign alloc_ready = (occ < PW'(DEPTH));
  assign alloc_tag   = tail_idx;
  assign fire        = alloc_req & alloc_ready;
  assign alloc_clr   = fire ? (DEPTH'(1) << tail_idx) : '0;

  // A broadcast lands only if its tag lies in [head, tail).
  for (genvar i = 0; i < N_CDB; i++) begin : g_cdb
    logic [ROB_WIDTH-1:0] off;
    assign off        = cdb_tag[i*ROB_WIDTH +: ROB_WIDTH] - head_idx;
    assign cdb_hit[i] = cdb_valid[i] & ({1'b0, off} < occ);
  end

  always_comb begin
    cdb_we = '0;
    for (int e = 0; e < DEPTH; e++) cdb_wd[e] = '0;
    for (int i = 0; i < N_CDB; i++) begin
      if (cdb_hit[i]) begin
        cdb_we[cdb_tag[i*ROB_WIDTH +: ROB_WIDTH]] = 1'b1;
        cdb_wd[cdb_tag[i*ROB_WIDTH +: ROB_WIDTH]] = cdb_data[i*32 +: 32];
      end
    end
  end

  for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_lane
    assign lane_idx[k] = head_idx + ROB_WIDTH'(k);
    assign lane_ok[k]  = (occ > PW'(k)) & ent_valid[lane_idx[k]];
    assign commit_arch[k*REG_WIDTH +: REG_WIDTH] = ent_arch[lane_idx[k]];
    assign commit_data[k*32 +: 32]               = ent_data[lane_idx[k]];
  end

  // Prefix-qualify lanes, then retire the leading run of acknowledged lanes.
  always_comb begin
    logic run;
    run          = 1'b1;
    commit_valid = '0;
    n_retire     = '0;
    ret_clr      = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      run             = run & lane_ok[k];
      commit_valid[k] = run;
    end
    run = 1'b1;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      run = run & commit_valid[k] & commit_ack[k];
      if (run) begin
        n_retire              = n_retire + PW'(1);
        ret_clr[lane_idx[k]]  = 1'b1;
      end
    end
  end

  // Lookup with bypass; the descending scan lets the lowest matching port win.
  for (genvar j = 0; j < N_READ; j++) begin : g_read
    logic [ROB_WIDTH-1:0] rt;
    logic                 rv;
    logic [31:0]          rd;
    assign rt = read_tag[j*ROB_WIDTH +: ROB_WIDTH];
    always_comb begin
      rv = ent_valid[rt];
      rd = ent_data[rt];
      for (int i = N_CDB - 1; i >= 0; i--) begin
        if (cdb_valid[i] && (cdb_tag[i*ROB_WIDTH +: ROB_WIDTH] == rt)) begin
          rv = 1'b1;
          rd = cdb_data[i*32 +: 32];
        end
      end
    end
    assign read_valid[j]         = rv;
    assign read_data[j*32 +: 32] = rd;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
    end else begin
      head <= head + n_retire;
      if (fire) tail <= tail + PW'(1);
      // Allocation clears last so it wins over a same-cycle broadcast.
      ent_valid <= (ent_valid | cdb_we) & ~ret_clr & ~alloc_clr;
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (fire && (tail_idx == ROB_WIDTH'(e))) ent_arch[e] <= alloc_arch;
        if (cdb_we[e]) ent_data[e] <= cdb_wd[e];
      end
    end
  end
endmodule

// File: tb/tb_rob_multi.sv
// Bench for rob_multi: directed scenarios plus randomized traffic, checked against
// an in-order queue model; retirements are checked by a monitor against exp_q.
module tb_rob_multi;
  localparam int RW = 4, GW = 5, NC = 3, NR = 2, CW = 2, DEPTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             alloc_req;
  logic [GW-1:0]    alloc_arch;
  logic             alloc_ready;
  logic [RW-1:0]    alloc_tag;
  logic [NC-1:0]    cdb_valid;
  logic [NC*RW-1:0] cdb_tag;
  logic [NC*32-1:0] cdb_data;
  logic [NR*RW-1:0] read_tag;
  logic [NR-1:0]    read_valid;
  logic [NR*32-1:0] read_data;
  logic [CW-1:0]    commit_valid;
  logic [CW*GW-1:0] commit_arch;
  logic [CW*32-1:0] commit_data;
  logic [CW-1:0]    commit_ack;
  logic             flush;
  logic [RW:0]      count;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: program-order queue of tags plus per-tag fields.
  logic [GW+31:0] exp_q[$];
  int             rob_q[$];
  logic           m_done [DEPTH];
  logic [GW-1:0]  m_arch [DEPTH];
  logic [31:0]    m_data [DEPTH];
  int             m_tail;
  logic [31:0]    plan_data;

  rob_multi #(.ROB_WIDTH(RW), .REG_WIDTH(GW), .N_CDB(NC), .N_READ(NR), .COMMIT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_arch(alloc_arch), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .read_tag(read_tag), .read_valid(read_valid), .read_data(read_data),
    .commit_valid(commit_valid), .commit_arch(commit_arch), .commit_data(commit_data),
    .commit_ack(commit_ack), .flush(flush), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_rob(input int t);
    foreach (rob_q[i]) if (rob_q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [CW-1:0] model_cv();
    logic [CW-1:0] cv;
    cv = '0;
    for (int k = 0; k < CW; k++) begin
      if (k < rob_q.size() && m_done[rob_q[k]]) cv[k] = 1'b1;
      else break;
    end
    return cv;
  endfunction

  task automatic model_reset();
    rob_q.delete();
    exp_q.delete();
    m_tail = 0;
    for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
  endtask

  task automatic idle();
    alloc_req  = 1'b0;
    alloc_arch = '0;
    cdb_valid  = '0;
    cdb_tag    = '0;
    cdb_data   = '0;
    read_tag   = '0;
    commit_ack = '0;
    flush      = 1'b0;
    plan_data  = $urandom;
  endtask

  task automatic set_cdb(input int p, input int t, input logic [31:0] d);
    cdb_valid[p]        = 1'b1;
    cdb_tag[p*RW +: RW] = RW'(t);
    cdb_data[p*32 +: 32] = d;
  endtask

  task automatic check_comb();
    chk("count", count, rob_q.size());
    chk("alloc_ready", alloc_ready, rob_q.size() < DEPTH);
    chk("alloc_tag", alloc_tag, m_tail);
    chk("commit_valid", commit_valid, model_cv());
    for (int j = 0; j < NR; j++) begin
      int t;
      bit ev;
      t  = int'(read_tag[j*RW +: RW]);
      if (in_rob(t)) begin
        ev = m_done[t];
        for (int i = 0; i < NC; i++)
          if (cdb_valid[i] && int'(cdb_tag[i*RW +: RW]) == t) ev = 1'b1;
        chk($sformatf("read_valid%0d_tag%0d", j, t), read_valid[j], ev);
        if (ev) chk($sformatf("read_data%0d_tag%0d", j, t), read_data[j*32 +: 32], m_data[t]);
      end
    end
  endtask

  task automatic update_model();
    bit fire, run;
    int n, t;
    if (flush) begin
      model_reset();
      return;
    end
    fire = alloc_req && (rob_q.size() < DEPTH);
    n = 0;
    run = 1'b1;
    for (int k = 0; k < CW; k++) begin
      run = run && model_cv()[k] && commit_ack[k];
      if (run) n++;
    end
    for (int i = 0; i < NC; i++) begin
      t = int'(cdb_tag[i*RW +: RW]);
      if (cdb_valid[i] && in_rob(t)) m_done[t] = 1'b1;
    end
    repeat (n) begin
      t = rob_q.pop_front();
      m_done[t] = 1'b0;
    end
    if (fire) begin
      t = m_tail;
      rob_q.push_back(t);
      m_done[t] = 1'b0;
      m_arch[t] = alloc_arch;
      m_data[t] = plan_data;
      exp_q.push_back({alloc_arch, plan_data});
      m_tail = (m_tail + 1) % DEPTH;
    end
  endtask

  task automatic cycle();
    #1;
    check_comb();
    @(posedge clk);
    update_model();
    @(negedge clk);
  endtask

  task automatic drive_random(input int alloc_pct);
    int pend[$];
    int p, t, idx;
    foreach (rob_q[i]) if (!m_done[rob_q[i]]) pend.push_back(rob_q[i]);
    flush      = ($urandom_range(0, 99) < 2);
    alloc_req  = ($urandom_range(0, 99) < alloc_pct);
    alloc_arch = GW'($urandom);
    commit_ack = CW'($urandom_range(0, 3));
    for (int i = 0; i < NC; i++) begin
      p = $urandom_range(0, 99);
      if (p < 45 && pend.size() > 0) begin
        idx = $urandom_range(0, pend.size() - 1);
        set_cdb(i, pend[idx], m_data[pend[idx]]);
        pend.delete(idx);
      end else if (p < 60 && rob_q.size() < DEPTH) begin
        t = $urandom_range(0, DEPTH - 1);
        for (int s = 0; s < DEPTH; s++) begin
          bit clash;
          clash = in_rob(t);
          for (int q = 0; q < i; q++)
            if (cdb_valid[q] && int'(cdb_tag[q*RW +: RW]) == t) clash = 1'b1;
          if (!clash) break;
          t = (t + 1) % DEPTH;
        end
        if (!in_rob(t)) set_cdb(i, t, $urandom);
      end
    end
    for (int j = 0; j < NR; j++)
      if (rob_q.size() > 0) read_tag[j*RW +: RW] = RW'(rob_q[$urandom_range(0, rob_q.size() - 1)]);
  endtask

  // Retirement monitor: pops one expectation per retired lane.
  initial begin
    bit run;
    logic [GW+31:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset !== 1'b0 || flush) continue;
      run = 1'b1;
      for (int k = 0; k < CW; k++) begin
        run = run && commit_valid[k] && commit_ack[k];
        if (run) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL retire_order: lane %0d retired, got arch %0h expected nothing", k, commit_arch[k*GW +: GW]);
          end else begin
            e = exp_q.pop_front();
            chk($sformatf("commit_arch%0d", k), commit_arch[k*GW +: GW], e[GW+31:32]);
            chk($sformatf("commit_data%0d", k), commit_data[k*32 +: 32], e[31:0]);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", count, 0);
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_alloc_tag", alloc_tag, 0);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_read_valid", read_valid, 0);
    reset = 1'b0;
    @(negedge clk);

    // Fill all 16 entries, tag 9 carries a known result.
    for (int k = 0; k < DEPTH; k++) begin
      idle();
      alloc_req  = 1'b1;
      alloc_arch = GW'(k);
      plan_data  = (k == 9) ? 32'hDEADBEEF : $urandom;
      #1 chk("fill_alloc_tag", alloc_tag, k);
      cycle();
    end
    idle();
    alloc_req = 1'b1;
    #1;
    chk("full_alloc_ready", alloc_ready, 0);
    chk("full_count", count, 16);
    cycle();
    idle();
    #1;
    chk("full_tail_hold", alloc_tag, 0);
    chk("full_count_hold", count, 16);
    cycle();

    // Three simultaneous broadcasts, visible next cycle.
    idle();
    set_cdb(0, 3, m_data[3]);
    set_cdb(1, 5, m_data[5]);
    set_cdb(2, 7, m_data[7]);
    cycle();
    idle();
    read_tag = {4'd5, 4'd3};
    #1;
    chk("cdb3_5_valid", read_valid, 2'b11);
    chk("cdb_read_tag3", read_data[31:0], m_data[3]);
    chk("cdb_read_tag5", read_data[63:32], m_data[5]);
    cycle();
    idle();
    read_tag = {4'd4, 4'd7};
    #1;
    chk("cdb7_4_valid", read_valid, 2'b01);
    chk("cdb_read_tag7", read_data[31:0], m_data[7]);
    cycle();

    // Same-cycle bypass of tag 9 from port 1.
    idle();
    read_tag = {4'd0, 4'd9};
    set_cdb(1, 9, 32'hDEADBEEF);
    #1;
    chk("bypass_valid", read_valid[0], 1);
    chk("bypass_data", read_data[31:0], 32'hDEADBEEF);
    cycle();

    // Head invalid blocks commit; CDB-to-commit latency is one cycle.
    idle();
    set_cdb(0, 1, m_data[1]);
    #1 chk("head_inv_cv", commit_valid, 2'b00);
    cycle();
    idle();
    #1 chk("head_inv_next_cv", commit_valid, 2'b00);
    cycle();
    idle();
    set_cdb(0, 0, m_data[0]);
    #1 chk("cdb_commit_latency", commit_valid, 2'b00);
    cycle();
    idle();
    #1 chk("two_valid_cv", commit_valid, 2'b11);
    cycle();

    // Full ROB: commit and alloc together, alloc must wait a cycle then wrap to tag 0.
    idle();
    commit_ack = 2'b01;
    alloc_req  = 1'b1;
    alloc_arch = 5'd20;
    #1 chk("full_commit_alloc_ready", alloc_ready, 0);
    cycle();
    idle();
    alloc_req  = 1'b1;
    alloc_arch = 5'd21;
    #1;
    chk("after_commit_count", count, 15);
    chk("wrap_alloc_tag", alloc_tag, 0);
    chk("wrap_alloc_ready", alloc_ready, 1);
    cycle();
    idle();
    #1 chk("wrap_count", count, 16);
    cycle();

    // Non-prefix ack ignored, then a two-lane retirement.
    idle();
    commit_ack = 2'b11;
    #1 chk("prefix_cv", commit_valid, 2'b01);
    cycle();
    idle();
    set_cdb(2, 2, m_data[2]);
    #1 chk("prefix_count", count, 15);
    cycle();
    idle();
    commit_ack = 2'b11;
    #1 chk("dual_cv", commit_valid, 2'b11);
    cycle();
    idle();
    #1;
    chk("dual_after_cv", commit_valid, 2'b00);
    chk("dual_after_count", count, 13);
    cycle();

    // Flush beats alloc, CDB and ack in the same cycle.
    idle();
    set_cdb(0, 4, m_data[4]);
    set_cdb(1, 6, m_data[6]);
    cycle();
    idle();
    flush      = 1'b1;
    alloc_req  = 1'b1;
    commit_ack = 2'b11;
    set_cdb(0, 8, m_data[8]);
    #1 chk("pre_flush_cv", commit_valid, 2'b11);
    cycle();
    idle();
    #1;
    chk("flush_count", count, 0);
    chk("flush_alloc_tag", alloc_tag, 0);
    chk("flush_cv", commit_valid, 2'b00);
    chk("flush_alloc_ready", alloc_ready, 1);
    cycle();

    // Asynchronous reset in mid-sequence.
    for (int k = 0; k < 3; k++) begin
      idle();
      alloc_req  = 1'b1;
      alloc_arch = GW'(k + 1);
      cycle();
    end
    idle();
    set_cdb(0, 0, m_data[0]);
    cycle();
    idle();
    #1 chk("pre_reset_cv", commit_valid, 2'b01);
    reset = 1'b1;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_alloc_tag", alloc_tag, 0);
    chk("async_rst_cv", commit_valid, 2'b00);
    chk("async_rst_alloc_ready", alloc_ready, 1);
    chk("async_rst_read_valid", read_valid, 2'b00);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic alternating light and heavy allocation pressure.
    for (int c = 0; c < 3000; c++) begin
      idle();
      drive_random(((c / 300) % 2) ? 90 : 40);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
